// File: rtl/jtdd_sdram_pkg.sv
// jtdd_sdram_pkg: SDRAM command codes, programming FSM states, default timing and FIFO entry layout.
// rev 1.0
`default_nettype none
`timescale 1ns/1ps

package jtdd_sdram_pkg;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  localparam int DEF_TRCD        = 2;
  localparam int DEF_TWR         = 2;
  localparam int DEF_TRP         = 2;
  localparam int DEF_TRFC        = 7;
  localparam int DEF_REFRESH_CYC = 374;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACT  = 3'd1,
    ST_WR   = 3'd2,
    ST_RCV  = 3'd3,
    ST_REF  = 3'd4
  } state_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } prog_entry_t;

endpackage

`default_nettype wire

// File: rtl/jtdd_prog_fifo.sv
// jtdd_prog_fifo: 4-deep, 32-bit FIFO buffering download writes ahead of the SDRAM sequencer.
// rev 1.0
`default_nettype none
`timescale 1ns/1ps

module jtdd_prog_fifo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] head,
  output logic        full,
  output logic        empty
);

  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        do_push;
  logic        do_pop;

  // Push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtdd_sdram_prog.sv
// jtdd_sdram_prog: download-time SDRAM writer (ACTIVE -> WRITE with auto-precharge, periodic refresh).
// rev 1.0
`default_nettype none
`timescale 1ns/1ps

module jtdd_sdram_prog
  import jtdd_sdram_pkg::*;
#(
  parameter int TRCD        = DEF_TRCD,
  parameter int TWR         = DEF_TWR,
  parameter int TRP         = DEF_TRP,
  parameter int TRFC        = DEF_TRFC,
  parameter int REFRESH_CYC = DEF_REFRESH_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_we,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_a,
  output logic [1:0]  sdram_dqm,
  output logic [15:0] sdram_dout,
  output logic        sdram_dq_oe,
  output logic        dwnld_busy,
  output logic        prog_ovf
);

  localparam int RCW = $clog2(REFRESH_CYC + 1);

  state_t         state;
  state_t         state_nx;
  logic [7:0]     wait_cnt;
  logic [7:0]     wait_nx;
  logic [RCW-1:0] ref_cnt;
  logic           ref_pend;
  logic           ref_expire;
  logic           ref_due;
  logic           ref_issue;
  logic           dl_q;
  logic           dl_rise;
  logic           drop;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [31:0]    fifo_head;
  prog_entry_t    head;
  prog_entry_t    cur;
  logic           busy_nx;
  logic           dq_oe_nx;
  logic [3:0]     cmd_nx;
  logic [1:0]     ba_nx;
  logic [1:0]     dqm_nx;
  logic [12:0]    a_nx;
  logic [15:0]    dout_nx;

  assign fifo_push  = prog_we & downloading & ~fifo_full;
  assign drop       = prog_we & downloading & fifo_full;
  assign dl_rise    = downloading & ~dl_q;
  assign head       = prog_entry_t'(fifo_head);
  assign ref_expire = dwnld_busy & (ref_cnt == RCW'(REFRESH_CYC - 1));
  // An expiry in the current cycle already counts, so it beats a write waiting in IDLE.
  assign ref_due    = ref_pend | ref_expire;
  assign ref_issue  = (state == ST_IDLE) & ref_due;
  assign fifo_pop   = (state == ST_IDLE) & ~ref_due & ~fifo_empty;

  jtdd_prog_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({prog_addr, prog_data, prog_mask}),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (ref_due) begin
          state_nx = ST_REF;
          wait_nx  = 8'(TRFC - 1);
        end else if (!fifo_empty) begin
          state_nx = ST_ACT;
          wait_nx  = 8'(TRCD - 1);
        end
      end
      ST_ACT: begin
        if (wait_cnt == 8'd0) state_nx = ST_WR;
        else                  wait_nx  = wait_cnt - 8'd1;
      end
      ST_WR: begin
        state_nx = ST_RCV;
        wait_nx  = 8'(TWR + TRP - 2);
      end
      ST_RCV, ST_REF: begin
        if (wait_cnt == 8'd0) state_nx = ST_IDLE;
        else                  wait_nx  = wait_cnt - 8'd1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered and registered below.
  always_comb begin
    busy_nx  = downloading | (state_nx != ST_IDLE) | ~fifo_empty;
    cmd_nx   = CMD_NOP;
    ba_nx    = sdram_ba;
    a_nx     = sdram_a;
    dqm_nx   = 2'b11;
    dout_nx  = sdram_dout;
    dq_oe_nx = 1'b0;
    if (ref_issue) begin
      cmd_nx = CMD_REF;
    end else if (fifo_pop) begin
      cmd_nx = CMD_ACT;
      ba_nx  = head.addr[21:20];
      a_nx   = {2'b00, head.addr[19:9]};
    end else if (state == ST_ACT && state_nx == ST_WR) begin
      cmd_nx   = CMD_WR;
      ba_nx    = cur.addr[21:20];
      a_nx     = {2'b00, 1'b1, 1'b0, cur.addr[8:0]};
      dqm_nx   = cur.mask;
      dout_nx  = {cur.data, cur.data};
      dq_oe_nx = 1'b1;
    end
    if (!busy_nx) cmd_nx = CMD_DESEL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdram_cmd   <= CMD_DESEL;
      sdram_ba    <= '0;
      sdram_a     <= '0;
      sdram_dqm   <= 2'b11;
      sdram_dout  <= '0;
      sdram_dq_oe <= 1'b0;
      dwnld_busy  <= 1'b0;
    end else begin
      sdram_cmd   <= cmd_nx;
      sdram_ba    <= ba_nx;
      sdram_a     <= a_nx;
      sdram_dqm   <= dqm_nx;
      sdram_dout  <= dout_nx;
      sdram_dq_oe <= dq_oe_nx;
      dwnld_busy  <= busy_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
      dl_q     <= 1'b0;
      prog_ovf <= 1'b0;
    end else begin
      if (fifo_pop) cur <= head;
      if (dwnld_busy) ref_cnt <= ref_expire ? '0 : ref_cnt + 1'b1;
      if (ref_issue)       ref_pend <= 1'b0;
      else if (ref_expire) ref_pend <= 1'b1;
      dl_q     <= downloading;
      prog_ovf <= (prog_ovf & ~dl_rise) | drop;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtdd_sdram_prog.sv
// tb_jtdd_sdram_prog: directed and random stimulus against a timestamp-based model of the download writer.
`default_nettype none
`timescale 1ns/1ps

module tb_jtdd_sdram_prog;

  localparam int TRCD = 2;
  localparam int TWR  = 2;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int RC   = 374;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_dout;
  logic        sdram_dq_oe;
  logic        dwnld_busy;
  logic        prog_ovf;

  jtdd_sdram_prog #(
    .TRCD(TRCD), .TWR(TWR), .TRP(TRP), .TRFC(TRFC), .REFRESH_CYC(RC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .sdram_cmd   (sdram_cmd),
    .sdram_ba    (sdram_ba),
    .sdram_a     (sdram_a),
    .sdram_dqm   (sdram_dqm),
    .sdram_dout  (sdram_dout),
    .sdram_dq_oe (sdram_dq_oe),
    .dwnld_busy  (dwnld_busy),
    .prog_ovf    (prog_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: accepted writes sit in a queue; the engine is described by the
  // edge at which it may next issue a command and the edge of a pending WRITE.
  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } ent_t;

  ent_t mq[$];
  ent_t m_cur;
  int   edge_n = 0;
  int   free_edge = 0;
  int   wr_edge = -1;
  int   ref_cnt = 0;
  bit   ref_pend = 0;
  bit   m_busy = 0;
  bit   m_ovf = 0;
  bit   dl_prev = 0;
  bit   do_ref, do_act, do_wr;
  logic [3:0] exp_cmd;
  int   wr_edges[$];

  task automatic model_reset();
    mq.delete();
    free_edge = 0;
    wr_edge   = -1;
    ref_cnt   = 0;
    ref_pend  = 0;
    m_busy    = 0;
    m_ovf     = 0;
    dl_prev   = 0;
  endtask

  task automatic model_step();
    bit expire, take, dropped;
    edge_n++;
    do_ref  = 0;
    do_act  = 0;
    do_wr   = (edge_n == wr_edge);
    expire  = m_busy && (ref_cnt == RC - 1);
    take    = prog_we && downloading && (mq.size() < 4);
    dropped = prog_we && downloading && (mq.size() == 4);
    if (edge_n >= free_edge) begin
      if (ref_pend || expire) begin
        do_ref    = 1;
        free_edge = edge_n + TRFC + 1;
      end else if (mq.size() > 0) begin
        m_cur     = mq.pop_front();
        do_act    = 1;
        wr_edge   = edge_n + TRCD;
        free_edge = edge_n + TRCD + TWR + TRP + 1;
      end
    end
    if (take) mq.push_back('{prog_addr, prog_data, prog_mask});
    if (m_busy) ref_cnt = expire ? 0 : ref_cnt + 1;
    if (do_ref)      ref_pend = 0;
    else if (expire) ref_pend = 1;
    if (downloading && !dl_prev) m_ovf = 0;
    if (dropped) m_ovf = 1;
    dl_prev = downloading;
    m_busy  = downloading || (mq.size() > 0) || (edge_n <= free_edge - 2);
    if (!m_busy)     exp_cmd = 4'b1111;
    else if (do_ref) exp_cmd = 4'b0001;
    else if (do_act) exp_cmd = 4'b0011;
    else if (do_wr)  exp_cmd = 4'b0100;
    else             exp_cmd = 4'b0111;
  endtask

  task automatic check_outputs();
    check("cmd", sdram_cmd, exp_cmd);
    check("busy", dwnld_busy, m_busy);
    check("ovf", prog_ovf, m_ovf);
    check("oe", sdram_dq_oe, do_wr);
    check("dqm", sdram_dqm, do_wr ? m_cur.mask : 2'b11);
    if (do_act) begin
      check("act_ba", sdram_ba, m_cur.addr[21:20]);
      check("act_row", sdram_a, {2'b00, m_cur.addr[19:9]});
    end
    if (do_wr) begin
      check("wr_ba", sdram_ba, m_cur.addr[21:20]);
      check("wr_col", sdram_a, {4'b0010, m_cur.addr[8:0]});
      check("wr_dout", sdram_dout, {m_cur.data, m_cur.data});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    if (sdram_cmd == 4'b0100) wr_edges.push_back(edge_n);
  endtask

  task automatic strobe(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    prog_addr = a;
    prog_data = d;
    prog_mask = m;
    prog_we   = 1'b1;
    cycle();
    prog_we   = 1'b0;
  endtask

  task automatic rnd_strobe();
    strobe(22'($urandom), 8'($urandom), 2'($urandom));
  endtask

  task automatic check_reset();
    check("rst_cmd", sdram_cmd, 4'hF);
    check("rst_ba", sdram_ba, 0);
    check("rst_a", sdram_a, 0);
    check("rst_dout", sdram_dout, 0);
    check("rst_dqm", sdram_dqm, 2'b11);
    check("rst_oe", sdram_dq_oe, 0);
    check("rst_busy", dwnld_busy, 0);
    check("rst_ovf", prog_ovf, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int k;
    int rate;
    rst_n = 1'b0;
    downloading = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Strobes and address activity with no download in progress.
    for (int i = 0; i < 12; i++) begin
      prog_we   = i[0];
      prog_addr = 22'($urandom);
      prog_data = 8'($urandom);
      prog_mask = 2'($urandom);
      cycle();
    end
    prog_we = 1'b0;
    check("nodl_busy", dwnld_busy, 0);
    check("nodl_cmd", sdram_cmd, 4'hF);

    // Single write.
    downloading = 1'b1;
    repeat (3) cycle();
    strobe(22'h12_3456, 8'hA5, 2'b10);
    cycle();
    check("sw_act", sdram_cmd, 4'b0011);
    check("sw_ba", sdram_ba, 2'b01);
    check("sw_row", sdram_a, 13'h011A);
    cycle();
    check("sw_nop", sdram_cmd, 4'b0111);
    cycle();
    check("sw_wr", sdram_cmd, 4'b0100);
    check("sw_col", sdram_a, 13'h0456);
    check("sw_dqm", sdram_dqm, 2'b10);
    check("sw_dout", sdram_dout, 16'hA5A5);
    check("sw_oe", sdram_dq_oe, 1);
    repeat (6) cycle();

    // Burst of six strobes: five accepted, the sixth overflows.
    wr_edges.delete();
    repeat (6) rnd_strobe();
    check("burst_ovf", prog_ovf, 1);
    repeat (45) cycle();
    check("burst_nwr", wr_edges.size(), 5);
    for (int i = 1; i < wr_edges.size(); i++)
      check("burst_gap", wr_edges[i] - wr_edges[i-1], 7);

    // Drain: in-flight entry plus three buffered entries finish after downloading falls.
    wr_edges.delete();
    repeat (4) rnd_strobe();
    downloading = 1'b0;
    guard = 0;
    while (dwnld_busy && guard < 80) begin
      cycle();
      guard++;
    end
    check("drain_timeout", dwnld_busy, 0);
    check("drain_nwr", wr_edges.size(), 4);
    check("drain_fall", (wr_edges.size() > 0) ? edge_n - wr_edges[wr_edges.size()-1] : -1, 4);
    check("drain_desel", sdram_cmd, 4'hF);
    for (int i = 0; i < 8; i++) begin
      prog_we = $urandom_range(0, 1) == 1;
      prog_addr = 22'($urandom);
      cycle();
    end
    prog_we = 1'b0;
    check("post_drain_busy", dwnld_busy, 0);

    // Refresh expiry in the same cycle the FIFO first holds an entry.
    downloading = 1'b1;
    cycle();
    guard = 0;
    while (!(m_busy && ref_cnt == RC - 2 && mq.size() == 0 && edge_n + 2 >= free_edge)
           && guard < 2 * RC) begin
      cycle();
      guard++;
    end
    check("coll_sync", guard < 2 * RC, 1);
    rnd_strobe();
    cycle();
    check("coll_ref", sdram_cmd, 4'b0001);
    k = 0;
    do begin
      cycle();
      k++;
    end while (sdram_cmd != 4'b0011 && k < 20);
    check("coll_gap", k, 8);

    // Random traffic with download on/off phases.
    rate = 3;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) rate = $urandom_range(0, 8);
      if ($urandom_range(0, 99) == 0) downloading = ~downloading;
      prog_we   = ($urandom_range(0, rate) == 0);
      prog_addr = 22'($urandom);
      prog_data = 8'($urandom);
      prog_mask = 2'($urandom);
      cycle();
    end
    prog_we = 1'b0;

    // Reset while in ACT with two entries buffered.
    downloading = 1'b1;
    guard = 0;
    while (!(mq.size() == 0 && edge_n + 1 >= free_edge && !ref_pend && ref_cnt < RC - 12)
           && guard < 2 * RC) begin
      cycle();
      guard++;
    end
    check("rst_sync", guard < 2 * RC, 1);
    repeat (3) rnd_strobe();
    check("pre_rst_q", mq.size(), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_edges.delete();
    repeat (20) cycle();
    check("post_rst_nwr", wr_edges.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
